instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Writer-side companion to `instr_mem`: it fills the instruction memory before the pipeline runs. It accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit instruction words. Each word goes to the memory write port at byte addresses `base, base+4, …`, the same addressing the fetch stage uses on `F_valP`. The pipeline is held in reset (`cpu_hold`) until a load completes.

## Interface
Parameters:
- `DEPTH`, 64: instruction memory size in words.
- `LEN_W`, 7: width of `load_len`; must satisfy 2^LEN_W > DEPTH.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a load. Ignored unless state is IDLE or DONE.
- `load_len`  in  LEN_W  words to load; sampled on `start`.
- `base_addr`  in  32  byte address of the first word, multiple of 4; sampled on `start`.
- `in_byte`  in  8  stream data.
- `in_valid`  in  1  `in_byte` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_addr`  out  32  byte address of the write.
- `mem_wdata`  out  32  packed instruction word.
- `busy`  out  1  a load is in progress.
- `done`  out  1  the last load finished; level output.
- `err`  out  1  the last `start` was rejected because `load_len > DEPTH`.
- `cpu_hold`  out  1  holds the pipeline in reset.

## Operation
States: IDLE, RECV, WRITE, DONE. Encoding is two bits, IDLE=0.
- **Reset values:** IDLE; `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `err`=0, `cpu_hold`=1. Byte counter and word index are 0.
- **IDLE/DONE + `start`:**
  - Latch `load_len` and `base_addr`. Clear `done`, `err`, word index and byte counter.
  - If `load_len > DEPTH`: go to DONE with `err`=1. No writes.
  - Else if `load_len == 0`: go to DONE.
  - Else: go to RECV and set `cpu_hold`=1.
- **RECV:**
  - `in_ready`=1 and `busy`=1.
  - A byte is accepted when `in_valid && in_ready` at a rising edge. The byte shifts into the packer: byte 0 goes to [31:24], byte 3 to [7:0].
  - The byte counter is 2 bits. On the 4th accepted byte, go to WRITE.
- **WRITE:** one cycle.
  - `mem_we`=1, `in_ready`=0.
  - `mem_addr = base_addr + {index, 2'b00}`, 32-bit, wrapping modulo 2^32.
  - `mem_wdata` is the packed word.
  - Then increment the index. If index+1 == `load_len`, go to DONE; else go to RECV.
- **DONE:**
  - `done`=1, `busy`=0, `in_ready`=0.
  - `cpu_hold`=0, unless `err` is set, in which case it stays 1.
  - Remains in DONE until the next `start`.
- **`start` during RECV/WRITE:** ignored.
- **Input stalls:** `in_valid` may drop at any time. The partial word is retained indefinitely.
- **Reset mid-load:** immediate return to reset values. The partial word is discarded. Words already written are not rolled back.

## Timing
- Latency:
  - `start` to the first `in_ready`=1 is 1 cycle.
  - The 4th accepted byte to `mem_we` is 1 cycle.
  - The last `mem_we` to `done`=1 is 1 cycle.
- With `in_valid` held high, one word takes 5 cycles. N words take 5N cycles from the first `in_ready` to entering DONE.
- `mem_addr` and `mem_wdata` are registered. They are valid only while `mem_we`=1 and hold their last value otherwise.
- `cpu_hold` deasserts in the same cycle `done` asserts.
- `err` and `done` assert together, 1 cycle after `start`.

## Structure
- Shared package `loader_pkg`:
  - State encoding constants: `LD_IDLE`, `LD_RECV`, `LD_WRITE`, `LD_DONE`.
  - `BYTES_PER_WORD`=4.
- One sub-module, `byte_packer`: a 32-bit shift register with a 2-bit count.
  - Inputs: `clk`, `rst_n`, `clr`, `shift_en`, `in_byte`.
  - Outputs: `word`, `full`. `full` pulses on the 4th shift.
- The FSM and address arithmetic live in `instr_mem_loader`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream. All outputs return to reset values (`cpu_hold`=1) and the next load starts clean.
- **Basic load:** `start`, `load_len`=2, `base_addr`=0, bytes 8C 01 00 04 00 22 18 20 with `in_valid` held high. Required:
  - writes (0x0, 0x8C010004) and (0x4, 0x00221820), 5 cycles apart;
  - `done`=1 and `cpu_hold`=0 one cycle after the second write.
- **Stalled stream:** same data with `in_valid` toggling 1,0,0,1,… Same two writes with identical addresses and data; no spurious `mem_we`.
- **Boundary lengths:**
  - `load_len`=0: `done` one cycle after `start` with no writes.
  - `load_len`=DEPTH+1: `err`=1, `cpu_hold`=1, no writes.
  - `load_len`=DEPTH: the last address is 4·(DEPTH−1).
- **Nonzero base and reload:** `base_addr`=0x10, 1 word, writes at 0x10. A second `start` from DONE with `base_addr`=0x20 writes at 0x20, and `done` clears for the duration of the load.
- **Ignored start:** pulse `start` with a different `load_len` during RECV. The load continues with the original length and parameters.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and word geometry.
// Pure declarations; no logic, no latency, no flow control.
package loader_pkg;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_RECV  = 2'd1,
        LD_WRITE = 2'd2,
        LD_DONE  = 2'd3
    } ld_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

    // Byte address of a word slot; wraps modulo 2^32 like the fetch-side PC.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word shift register: the first byte lands in [31:24] once four are in.
// One byte per cycle when shift_en; full is a combinational pulse on the 4th shift.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        full
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            cnt  <= '0;
        end else if (clr) begin
            word <= '0;
            cnt  <= '0;
        end else if (shift_en) begin
            word <= {word[23:0], in_byte};
            cnt  <= cnt + 1'b1;
        end
    end

    assign full = shift_en && (cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a big-endian byte stream into instruction memory as 32-bit words at base, base+4, ...
// Stream is valid/ready: in_ready drops for the one-cycle write; 5 cycles per word at full rate.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] load_len,
    input  logic [31:0]      base_addr,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             cpu_hold
);

    localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(DEPTH);

    ld_state_t        state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] index;
    logic [LEN_W-1:0] index_nxt;
    logic [31:0]      base_q;
    logic [31:0]      pk_word;
    logic             pk_full;
    logic             accept;
    logic             start_ok;

    assign accept    = in_valid && in_ready;
    assign start_ok  = start && ((state == LD_IDLE) || (state == LD_DONE));
    assign index_nxt = index + 1'b1;

    byte_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_ok),
        .shift_en (accept),
        .in_byte  (in_byte),
        .word     (pk_word),
        .full     (pk_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LD_IDLE;
            len_q     <= '0;
            index     <= '0;
            base_q    <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_hold  <= 1'b1;
        end else begin
            case (state)
                LD_IDLE, LD_DONE: begin
                    if (start) begin
                        len_q  <= load_len;
                        base_q <= base_addr;
                        index  <= '0;
                        done   <= 1'b0;
                        err    <= 1'b0;
                        if ({1'b0, load_len} > DEPTH_L) begin
                            // Oversized request: report and keep the core parked.
                            state    <= LD_DONE;
                            err      <= 1'b1;
                            done     <= 1'b1;
                            cpu_hold <= 1'b1;
                        end else if (load_len == '0) begin
                            state    <= LD_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state    <= LD_RECV;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
                end
                LD_RECV: begin
                    if (pk_full) begin
                        // The packer register updates on this same edge, so fold the 4th byte in here.
                        state     <= LD_WRITE;
                        in_ready  <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_addr  <= word_addr(base_q, 32'(index));
                        mem_wdata <= {pk_word[23:0], in_byte};
                    end
                end
                LD_WRITE: begin
                    mem_we <= 1'b0;
                    index  <= index_nxt;
                    if (index_nxt == len_q) begin
                        state    <= LD_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state    <= LD_RECV;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= LD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: writes are predicted into a scoreboard as bytes are queued.
// A negedge monitor pops and compares every mem_we; the main sequence checks control outputs.
module tb_instr_mem_loader;

    localparam int DEPTH = 64;
    localparam int LEN_W = 7;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] load_len;
    logic [31:0]      base_addr;
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             in_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             busy;
    logic             done;
    logic             err;
    logic             cpu_hold;

    instr_mem_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .load_len  (load_len),
        .base_addr (base_addr),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_hold  (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_writes = 0;
    int          last_we_cyc = 0;
    logic [31:0] last_addr = '0;
    logic [63:0] sb[$];
    logic [7:0]  tx_q[$];
    int          we_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (rst_n && mem_we) begin
            n_writes++;
            we_cyc.push_back(cyc);
            last_we_cyc = cyc;
            last_addr   = mem_addr;
            check("we_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", mem_addr, e[63:32]);
                check("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic queue_word(input logic [31:0] addr, input logic [31:0] data);
        sb.push_back({addr, data});
        for (int i = 0; i < 4; i++) tx_q.push_back(data[31-8*i -: 8]);
    endtask

    // Called and returning 1 time unit after a rising edge.
    task automatic do_start(input logic [LEN_W-1:0] len, input logic [31:0] base);
        start     = 1'b1;
        load_len  = len;
        base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int n, input bit stall, input string tag);
        int   sent  = 0;
        int   k     = 0;
        logic rdy;
        while (sent < n && k < 3000) begin
            in_byte  = tx_q[0];
            in_valid = stall ? ((k % 3) == 0) : 1'b1;
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            if (in_valid && rdy) begin
                void'(tx_q.pop_front());
                sent++;
            end
            k++;
        end
        in_valid = 1'b0;
        if (sent < n) check({tag, "_send_timeout"}, 32'(sent), 32'(n));
    endtask

    task automatic wait_done(input string tag, input bit check_lat);
        int g = 0;
        @(negedge clk);
        while (!done && g < 100) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        if (check_lat) check({tag, "_done_lat"}, 32'(cyc - last_we_cyc), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst_n     = 1'b0;
        start     = 1'b0;
        load_len  = '0;
        base_addr = '0;
        in_byte   = '0;
        in_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic two-word load at full rate
        we_cyc.delete();
        do_start(7'd2, 32'h0);
        check("basic_rdy_lat", 32'(in_ready), 32'd1);
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_hold", 32'(cpu_hold), 32'd1);
        queue_word(32'h0, 32'h8C010004);
        queue_word(32'h4, 32'h00221820);
        send(8, 1'b0, "basic");
        wait_done("basic", 1'b1);
        check("basic_hold_rel", 32'(cpu_hold), 32'd0);
        check("basic_busy_clr", 32'(busy), 32'd0);
        check("basic_nwr", 32'(we_cyc.size()), 32'd2);
        if (we_cyc.size() == 2) check("basic_spacing", 32'(we_cyc[1] - we_cyc[0]), 32'd5);
        check("basic_sb_empty", 32'(sb.size()), 32'd0);

        // Same data with a stalling source
        n0 = n_writes;
        do_start(7'd2, 32'h0);
        queue_word(32'h0, 32'h8C010004);
        queue_word(32'h4, 32'h00221820);
        send(8, 1'b1, "stall");
        wait_done("stall", 1'b1);
        check("stall_nwr", 32'(n_writes - n0), 32'd2);
        check("stall_sb_empty", 32'(sb.size()), 32'd0);

        // Zero-length load
        n0 = n_writes;
        do_start(7'd0, 32'h0);
        check("len0_done", 32'(done), 32'd1);
        check("len0_err", 32'(err), 32'd0);
        check("len0_hold", 32'(cpu_hold), 32'd0);
        check("len0_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("len0_nwr", 32'(n_writes - n0), 32'd0);

        // Oversized load
        do_start(7'(DEPTH + 1), 32'h0);
        check("over_err", 32'(err), 32'd1);
        check("over_done", 32'(done), 32'd1);
        check("over_hold", 32'(cpu_hold), 32'd1);
        check("over_rdy", 32'(in_ready), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("over_nwr", 32'(n_writes - n0), 32'd0);

        // Full-depth load with random words
        n0 = n_writes;
        do_start(7'(DEPTH), 32'h0);
        check("full_err_clr", 32'(err), 32'd0);
        for (int w = 0; w < DEPTH; w++) queue_word(32'(w * 4), $urandom);
        send(4 * DEPTH, 1'b0, "full");
        wait_done("full", 1'b1);
        check("full_nwr", 32'(n_writes - n0), 32'(DEPTH));
        check("full_last_addr", last_addr, 32'(4 * (DEPTH - 1)));
        check("full_sb_empty", 32'(sb.size()), 32'd0);

        // Nonzero base, then reload from DONE
        do_start(7'd1, 32'h10);
        queue_word(32'h10, 32'hDEADBEEF);
        send(4, 1'b0, "base10");
        wait_done("base10", 1'b1);
        check("base10_addr", last_addr, 32'h10);
        do_start(7'd1, 32'h20);
        check("reload_done_clr", 32'(done), 32'd0);
        check("reload_busy", 32'(busy), 32'd1);
        check("reload_hold", 32'(cpu_hold), 32'd1);
        queue_word(32'h20, 32'hCAFEF00D);
        send(2, 1'b0, "reload_a");
        check("reload_done_mid", 32'(done), 32'd0);
        send(2, 1'b0, "reload_b");
        wait_done("reload", 1'b1);
        check("reload_addr", last_addr, 32'h20);
        check("reload_sb_empty", 32'(sb.size()), 32'd0);

        // start during RECV must be ignored
        n0 = n_writes;
        do_start(7'd2, 32'h40);
        queue_word(32'h40, 32'h11223344);
        queue_word(32'h44, 32'h55667788);
        send(2, 1'b0, "ign_a");
        start     = 1'b1;
        load_len  = 7'd1;
        base_addr = 32'h80;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        check("ign_rdy", 32'(in_ready), 32'd1);
        send(6, 1'b0, "ign_b");
        wait_done("ign", 1'b1);
        check("ign_nwr", 32'(n_writes - n0), 32'd2);
        check("ign_last_addr", last_addr, 32'h44);
        check("ign_sb_empty", 32'(sb.size()), 32'd0);

        // Reset in the middle of the second word
        n0 = n_writes;
        do_start(7'd2, 32'h0);
        queue_word(32'h0, 32'hA1B2C3D4);
        tx_q.push_back(8'hEE);
        send(5, 1'b0, "midrst");
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        tx_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_nwr", 32'(n_writes - n0), 32'd1);
        check("midrst_sb_empty", 32'(sb.size()), 32'd0);
        do_start(7'd1, 32'h100);
        queue_word(32'h100, 32'h12345678);
        send(4, 1'b0, "postrst");
        wait_done("postrst", 1'b1);
        check("postrst_addr", last_addr, 32'h100);
        check("postrst_hold", 32'(cpu_hold), 32'd0);
        check("postrst_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
